// File: rtl/rtc_port_bridge.sv
// PicoBlaze port-bus bridge to the RTC bus engine: windowed posted writes,
// command-launched reads, pollable status with sticky error bits and a bus timeout.
module rtc_port_bridge #(
    parameter int DATA_W        = 8,
    parameter int PORT_W        = 8,
    parameter int RTC_ADDR_W    = 8,
    parameter int N_REGS        = 16,
    parameter int WR_BASE_PORT  = 'h20,
    parameter int RTC_ADDR_BASE = 1,
    parameter int RD_CMD_PORT   = 'h0A,
    parameter int RDATA_PORT    = 'h0B,
    parameter int STATUS_PORT   = 'h0C,
    parameter int TIMEOUT_CYC   = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORT_W-1:0]     port_id,
    input  logic [DATA_W-1:0]     out_port,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    output logic [DATA_W-1:0]     in_port,
    output logic                  rtc_wr_req,
    output logic                  rtc_rd_req,
    output logic [RTC_ADDR_W-1:0] rtc_addr,
    output logic [DATA_W-1:0]     rtc_wdata,
    input  logic                  rtc_wr_done,
    input  logic                  rtc_rd_done,
    input  logic [DATA_W-1:0]     rtc_rdata,
    output logic                  busy
);

    localparam int               CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_WAIT,
        S_RD_WAIT,
        S_RECOVER
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overrun;
    logic                  r_addr_err;
    logic                  r_timeout_err;
    logic [2:0]            r_clr_mask;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_in_port;
    logic                  r_wr_req;
    logic                  r_rd_req;
    logic [RTC_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;

    logic [31:0]           w_port_ext;
    logic [31:0]           w_wr_off;
    logic [31:0]           w_rd_idx;
    logic                  w_is_win;
    logic                  w_is_rdcmd;
    logic                  w_rd_idx_ok;
    logic                  w_is_cmd;
    logic                  w_status_rd;
    logic                  w_ovr_evt;
    logic                  w_aerr_evt;
    logic                  w_tmo_evt;
    logic [2:0]            w_sticky;
    logic [DATA_W-1:0]     w_status;

    // NOTE: every w_ signal gets an unconditional value at the top of the block,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_port_ext  = 32'(port_id);
        w_wr_off    = w_port_ext - 32'(WR_BASE_PORT);
        w_rd_idx    = 32'(out_port);
        w_is_win    = (w_port_ext >= 32'(WR_BASE_PORT)) && (w_wr_off < 32'(N_REGS));
        w_is_rdcmd  = (port_id == PORT_W'(RD_CMD_PORT)) && !w_is_win;
        w_rd_idx_ok = (w_rd_idx < 32'(N_REGS));
        w_is_cmd    = write_strobe && (w_is_win || w_is_rdcmd);
        w_status_rd = read_strobe && (port_id == PORT_W'(STATUS_PORT));

        w_ovr_evt   = w_is_cmd && (r_state != S_IDLE);
        w_aerr_evt  = (r_state == S_IDLE) && write_strobe && w_is_rdcmd && !w_rd_idx_ok;
        w_tmo_evt   = (r_cnt == LP_CNT_LAST) &&
                      (((r_state == S_WR_WAIT) && !rtc_wr_done) ||
                       ((r_state == S_RD_WAIT) && !rtc_rd_done));

        w_sticky      = {r_timeout_err, r_addr_err, r_overrun};
        w_status      = '0;
        w_status[4:0] = {r_timeout_err, r_addr_err, r_overrun, r_done, r_busy};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_addr_err    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_clr_mask    <= '0;
            r_rdata       <= '0;
            r_in_port     <= '0;
            r_wr_req      <= 1'b0;
            r_rd_req      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else begin
            if (port_id == PORT_W'(STATUS_PORT)) begin
                r_in_port <= w_status;
            end else if (port_id == PORT_W'(RDATA_PORT)) begin
                r_in_port <= r_rdata;
            end else begin
                r_in_port <= '0;
            end

            // Clear only the sticky bits that the status read actually reported;
            // an event arriving on the clearing edge is ORed back in and survives.
            r_clr_mask    <= w_status_rd ? w_sticky : 3'b000;
            r_overrun     <= (r_overrun     & ~r_clr_mask[0]) | w_ovr_evt;
            r_addr_err    <= (r_addr_err    & ~r_clr_mask[1]) | w_aerr_evt;
            r_timeout_err <= (r_timeout_err & ~r_clr_mask[2]) | w_tmo_evt;

            case (r_state)
                S_IDLE: begin
                    if (write_strobe && w_is_win) begin
                        r_addr   <= RTC_ADDR_W'(32'(RTC_ADDR_BASE) + w_wr_off);
                        r_wdata  <= out_port;
                        r_wr_req <= 1'b1;
                        r_cnt    <= '0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_WR_WAIT;
                    end else if (write_strobe && w_is_rdcmd && w_rd_idx_ok) begin
                        r_addr   <= RTC_ADDR_W'(32'(RTC_ADDR_BASE) + w_rd_idx);
                        r_rd_req <= 1'b1;
                        r_cnt    <= '0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RD_WAIT;
                    end
                end

                S_WR_WAIT: begin
                    if (rtc_wr_done) begin
                        r_wr_req <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_RECOVER;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_wr_req <= 1'b0;
                        r_state  <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RD_WAIT: begin
                    if (rtc_rd_done) begin
                        r_rd_req <= 1'b0;
                        r_done   <= 1'b1;
                        r_rdata  <= rtc_rdata;
                        r_state  <= S_RECOVER;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_rd_req <= 1'b0;
                        r_state  <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RECOVER: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_port    = r_in_port;
    assign rtc_wr_req = r_wr_req;
    assign rtc_rd_req = r_rd_req;
    assign rtc_addr   = r_addr;
    assign rtc_wdata  = r_wdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_rtc_port_bridge.sv
// Bench for rtc_port_bridge: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_rtc_port_bridge;

    localparam int TMO = 8;
    localparam int NR  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       rtc_wr_req;
    logic       rtc_rd_req;
    logic [7:0] rtc_addr;
    logic [7:0] rtc_wdata;
    logic       rtc_wr_done;
    logic       rtc_rd_done;
    logic [7:0] rtc_rdata;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rtc_port_bridge #(
        .DATA_W(8), .PORT_W(8), .RTC_ADDR_W(8), .N_REGS(NR),
        .WR_BASE_PORT('h20), .RTC_ADDR_BASE(1), .RD_CMD_PORT('h0A),
        .RDATA_PORT('h0B), .STATUS_PORT('h0C), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .rtc_wr_req(rtc_wr_req), .rtc_rd_req(rtc_rd_req), .rtc_addr(rtc_addr),
        .rtc_wdata(rtc_wdata), .rtc_wr_done(rtc_wr_done), .rtc_rd_done(rtc_rd_done),
        .rtc_rdata(rtc_rdata), .busy(busy)
    );

    typedef struct {
        logic [7:0] port;
        logic [7:0] data;
        logic       ws;
        logic       rs;
        logic       wdone;
        logic       exp_wr;
        logic       exp_busy;
        logic       chk_bus;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_in;
    } vec_t;

    vec_t vecs [10];

    // Transaction-level model: a transaction lives for len request cycles plus one gap cycle.
    bit         m_act;
    int         m_age;
    int         m_len;
    int         m_lat;
    int         m_kind;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic [7:0] m_in;
    bit         m_done;
    bit         m_ovr;
    bit         m_aerr;
    bit         m_tmo;
    logic [2:0] m_clr;
    int         l_pick;
    int         hi_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        rtc_wr_done  = 1'b0;
        rtc_rd_done  = 1'b0;
    endtask

    task automatic drive_wr(input logic [7:0] port, input logic [7:0] data);
        idle_inputs();
        port_id      = port;
        out_port     = data;
        write_strobe = 1'b1;
    endtask

    // One strobed STATUS read followed by an idle cycle so the read-clear lands.
    task automatic status_read(input string name, input logic [7:0] exp);
        idle_inputs();
        port_id     = 8'h0C;
        read_strobe = 1'b1;
        tick();
        check(name, in_port, exp);
        idle_inputs();
        tick();
    endtask

    function automatic vec_t mk(input logic [7:0] port, input logic [7:0] data,
                                input logic ws, input logic rs, input logic wdone,
                                input logic exp_wr, input logic exp_busy, input logic chk_bus,
                                input logic [7:0] exp_addr, input logic [7:0] exp_wdata,
                                input logic [7:0] exp_in);
        vec_t v;
        v.port = port; v.data = data; v.ws = ws; v.rs = rs; v.wdone = wdone;
        v.exp_wr = exp_wr; v.exp_busy = exp_busy; v.chk_bus = chk_bus;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_in = exp_in;
        return v;
    endfunction

    task automatic model_reset();
        m_act = 0; m_age = 0; m_len = 0; m_lat = 0; m_kind = 0;
        m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00; m_in = 8'h00;
        m_done = 0; m_ovr = 0; m_aerr = 0; m_tmo = 0; m_clr = 3'b000;
    endtask

    task automatic model_step(input int lat);
        logic [7:0] status;
        logic [2:0] sticky;
        bit         is_win;
        bit         is_rdc;
        bit         cmd;
        bit         ovr_e;
        bit         aerr_e;
        bit         tmo_e;
        status = {3'b000, m_tmo, m_aerr, m_ovr, m_done, m_act};
        sticky = {m_tmo, m_aerr, m_ovr};
        is_win = (port_id >= 8'h20) && (port_id <= 8'h2F);
        is_rdc = (port_id == 8'h0A);
        cmd    = write_strobe && (is_win || is_rdc);
        ovr_e  = cmd && m_act;
        aerr_e = !m_act && write_strobe && is_rdc && (out_port >= 8'(NR));
        tmo_e  = 0;
        if (port_id == 8'h0C)      m_in = status;
        else if (port_id == 8'h0B) m_in = m_rdata;
        else                       m_in = 8'h00;
        if (m_act) begin
            if (m_age == m_len - 1) begin
                if (m_lat <= TMO) begin
                    m_done = 1;
                    if (m_kind == 2) m_rdata = rtc_rdata;
                end else begin
                    tmo_e = 1;
                end
            end
            m_age++;
            if (m_age > m_len) m_act = 0;
        end else if (cmd && !aerr_e) begin
            m_act  = 1;
            m_age  = 0;
            m_lat  = lat;
            m_len  = (lat < TMO) ? lat : TMO;
            m_done = 0;
            if (is_win) begin
                m_kind  = 1;
                m_addr  = 8'(1 + (port_id - 8'h20));
                m_wdata = out_port;
            end else begin
                m_kind = 2;
                m_addr = 8'(1 + out_port);
            end
        end
        m_ovr  = (m_ovr  & !m_clr[0]) | ovr_e;
        m_aerr = (m_aerr & !m_clr[1]) | aerr_e;
        m_tmo  = (m_tmo  & !m_clr[2]) | tmo_e;
        m_clr  = (read_strobe && port_id == 8'h0C) ? sticky : 3'b000;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(8'h23, 8'h59, 1, 0, 0, 1, 1, 1, 8'h04, 8'h59, 8'h00);
        for (int i = 1; i <= 4; i++)
            vecs[i] = mk(8'h00, 8'h00, 0, 0, 0, 1, 1, 1, 8'h04, 8'h59, 8'h00);
        vecs[5] = mk(8'h00, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        vecs[7] = mk(8'h0C, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02);
        vecs[8] = mk(8'h0C, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02);
        vecs[9] = mk(8'h0B, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

        idle_inputs();
        rtc_rdata = 8'h00;
        reset = 1'b1;
        tick();
        check("reset_in_port", in_port, 8'h00);
        check("reset_wr_req", rtc_wr_req, 1'b0);
        check("reset_rd_req", rtc_rd_req, 1'b0);
        check("reset_addr", rtc_addr, 8'h00);
        check("reset_wdata", rtc_wdata, 8'h00);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        status_read("reset_status", 8'h00);

        // Posted write, status poll
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            port_id      = vecs[i].port;
            out_port     = vecs[i].data;
            write_strobe = vecs[i].ws;
            read_strobe  = vecs[i].rs;
            rtc_wr_done  = vecs[i].wdone;
            tick();
            check($sformatf("vec%0d_wr_req", i), rtc_wr_req, vecs[i].exp_wr);
            check($sformatf("vec%0d_rd_req", i), rtc_rd_req, 1'b0);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_in_port", i), in_port, vecs[i].exp_in);
            if (vecs[i].chk_bus) begin
                check($sformatf("vec%0d_addr", i), rtc_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wdata", i), rtc_wdata, vecs[i].exp_wdata);
            end
        end

        // Read launch, ignored non-matching done, data capture
        drive_wr(8'h0A, 8'h02);
        tick();
        check("rd_req_up", rtc_rd_req, 1'b1);
        check("rd_no_wr_req", rtc_wr_req, 1'b0);
        check("rd_addr", rtc_addr, 8'h03);
        idle_inputs();
        rtc_wr_done = 1'b1;
        tick();
        check("rd_ignores_wr_done", rtc_rd_req, 1'b1);
        idle_inputs();
        rtc_rd_done = 1'b1;
        rtc_rdata   = 8'h47;
        tick();
        check("rd_req_drop", rtc_rd_req, 1'b0);
        check("rd_recover_busy", busy, 1'b1);
        idle_inputs();
        rtc_rdata = 8'h00;
        port_id   = 8'h0B;
        tick();
        check("rd_data", in_port, 8'h47);
        check("rd_idle_busy", busy, 1'b0);
        status_read("rd_status", 8'h02);

        // Timeout: no done ever arrives
        drive_wr(8'h0A, 8'h05);
        tick();
        check("tmo_addr", rtc_addr, 8'h06);
        hi_cnt = rtc_rd_req ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            tick();
            if (!rtc_rd_req) break;
            hi_cnt++;
        end
        check("tmo_req_cycles", hi_cnt, TMO);
        check("tmo_recover_busy", busy, 1'b1);
        tick();
        check("tmo_idle_busy", busy, 1'b0);
        status_read("tmo_status", 8'h10);
        status_read("tmo_status_cleared", 8'h00);
        idle_inputs();
        port_id = 8'h0B;
        tick();
        check("tmo_rdata_kept", in_port, 8'h47);

        // Overrun during WR_WAIT, then addr_err
        drive_wr(8'h21, 8'h11);
        tick();
        check("ovr_first_req", rtc_wr_req, 1'b1);
        drive_wr(8'h25, 8'h99);
        tick();
        check("ovr_req_held", rtc_wr_req, 1'b1);
        check("ovr_addr_held", rtc_addr, 8'h02);
        check("ovr_wdata_held", rtc_wdata, 8'h11);
        idle_inputs();
        rtc_wr_done = 1'b1;
        tick();
        idle_inputs();
        tick();
        status_read("ovr_status", 8'h06);
        drive_wr(8'h0A, 8'h10);
        tick();
        check("aerr_no_req", rtc_rd_req, 1'b0);
        check("aerr_no_busy", busy, 1'b0);
        status_read("aerr_status", 8'h0A);
        status_read("aerr_status_cleared", 8'h02);

        // Ports just outside the write window are ignored
        drive_wr(8'h1F, 8'hAA);
        tick();
        check("below_window_no_req", rtc_wr_req, 1'b0);
        drive_wr(8'h30, 8'hAA);
        tick();
        check("above_window_no_req", rtc_wr_req, 1'b0);
        status_read("outside_window_status", 8'h02);

        // Back-to-back: command in RECOVER is dropped, next cycle's is accepted
        drive_wr(8'h2F, 8'h33);
        tick();
        check("b2b_top_addr", rtc_addr, 8'h10);
        check("b2b_first_req", rtc_wr_req, 1'b1);
        idle_inputs();
        rtc_wr_done = 1'b1;
        tick();
        check("b2b_gap1_req", rtc_wr_req, 1'b0);
        drive_wr(8'h20, 8'h44);
        tick();
        check("b2b_recover_drop_req", rtc_wr_req, 1'b0);
        check("b2b_busy_fell", busy, 1'b0);
        drive_wr(8'h22, 8'h55);
        tick();
        check("b2b_second_req", rtc_wr_req, 1'b1);
        check("b2b_second_addr", rtc_addr, 8'h03);
        check("b2b_second_wdata", rtc_wdata, 8'h55);
        idle_inputs();
        rtc_wr_done = 1'b1;
        tick();
        idle_inputs();
        tick();
        status_read("b2b_status", 8'h06);

        // Reset in the middle of a read
        drive_wr(8'h0A, 8'h0F);
        tick();
        check("rst_top_idx_addr", rtc_addr, 8'h10);
        idle_inputs();
        tick();
        check("rst_pre_req", rtc_rd_req, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_mid_rd_req", rtc_rd_req, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_addr", rtc_addr, 8'h00);
        reset = 1'b0;
        status_read("rst_mid_status", 8'h00);
        idle_inputs();
        port_id = 8'h0B;
        tick();
        check("rst_mid_rdata", in_port, 8'h00);

        // Randomized run against the model
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle_inputs();
            rtc_rdata = 8'($urandom);
            l_pick    = int'($urandom_range(1, TMO + 3));
            case ($urandom_range(0, 9))
                0, 1:    port_id = 8'(32'h20 + $urandom_range(0, 15));
                2:       port_id = ($urandom_range(0, 1) == 0) ? 8'h1F : 8'h30;
                3, 4:    port_id = 8'h0A;
                5:       port_id = 8'h0B;
                6, 7:    port_id = 8'h0C;
                default: port_id = 8'($urandom);
            endcase
            out_port     = (port_id == 8'h0A) ? 8'($urandom_range(0, 19)) : 8'($urandom);
            write_strobe = ($urandom_range(0, 3) == 0);
            read_strobe  = ($urandom_range(0, 2) == 0);
            if (m_act && m_age < m_len) begin
                if (m_lat <= TMO && m_age == m_lat - 1) begin
                    if (m_kind == 1) rtc_wr_done = 1'b1;
                    else             rtc_rd_done = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    if (m_kind == 1) rtc_rd_done = 1'b1;
                    else             rtc_wr_done = 1'b1;
                end
            end
            model_step(l_pick);
            tick();
            check("rnd_wr_req", rtc_wr_req, (m_act && m_age < m_len && m_kind == 1));
            check("rnd_rd_req", rtc_rd_req, (m_act && m_age < m_len && m_kind == 2));
            check("rnd_busy", busy, m_act);
            check("rnd_in_port", in_port, m_in);
            if (m_act && m_age < m_len) begin
                check("rnd_addr", rtc_addr, m_addr);
                if (m_kind == 1) check("rnd_wdata", rtc_wdata, m_wdata);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_port_bridge.md
Name: rtc_port_bridge

Overview:
Parametrised successor to the RTC main-control FSM. It bridges the PicoBlaze port bus (port_id/out_port/write_strobe/read_strobe) to the RTC bus engine. Decoding is a linear port window rather than a fixed lookup. Writes are posted, reads are command-launched, the status register is pollable, and both sticky error bits and a bus timeout replace open-ended waits.

Parameters:
DATA_W, 8, data width of port bus and RTC engine
PORT_W, 8, port_id width
RTC_ADDR_W, 8, RTC register address width
N_REGS, 16, RTC registers reachable (window size), 1..2^PORT_W
WR_BASE_PORT, 8'h20, first port of write window (WR_BASE_PORT+i writes register i)
RTC_ADDR_BASE, 1, rtc_addr = RTC_ADDR_BASE + i
RD_CMD_PORT, 8'h0A, write index i here to launch a read
RDATA_PORT, 8'h0B, read returns last captured read data
STATUS_PORT, 8'h0C, read returns status; read clears sticky bits
TIMEOUT_CYC, 1023, max cycles waiting for rtc done (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
port_id  in  PORT_W  PicoBlaze port address
out_port  in  DATA_W  PicoBlaze write data
write_strobe  in  1  one-cycle write qualifier
read_strobe  in  1  one-cycle read qualifier
in_port  out  DATA_W  registered read data to PicoBlaze
rtc_wr_req  out  1  level write request to RTC engine
rtc_rd_req  out  1  level read request to RTC engine
rtc_addr  out  RTC_ADDR_W  RTC register address, stable while req high
rtc_wdata  out  DATA_W  write data, stable while rtc_wr_req high
rtc_wr_done  in  1  one-cycle write completion
rtc_rd_done  in  1  one-cycle read completion, rtc_rdata valid same cycle
rtc_rdata  in  DATA_W  read data from RTC engine
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (sync, dominates all): in_port=0, rtc_wr_req=0, rtc_rd_req=0, rtc_addr=0, rtc_wdata=0, busy=0, rdata reg=0, all status bits=0, timeout counter=0, state=IDLE. Reset mid-transaction drops requests on the next edge with no completion flagged.
- Status byte: bit0 busy, bit1 done (set on completion, cleared when a new command is accepted), bit2 overrun, bit3 addr_err, bit4 timeout_err. Upper bits are 0. Bits 2-4 are sticky until a STATUS_PORT read.
- in_port is registered every cycle from the current port_id: STATUS_PORT gives status, RDATA_PORT gives rdata, any other port gives 0. Latency is 1 cycle, which matches the KCPSM INPUT sampling.
- STATUS read-clear: on read_strobe with port_id==STATUS_PORT, clear bits 2-4 one cycle after in_port captured them. An error event in that same cycle wins and stays set.
- FSM states: IDLE, WR_WAIT, RD_WAIT, RECOVER.
- IDLE, write_strobe in window [WR_BASE_PORT, WR_BASE_PORT+N_REGS-1]: latch rtc_addr=RTC_ADDR_BASE+(port_id-WR_BASE_PORT) and rtc_wdata=out_port. Assert rtc_wr_req next cycle, go to WR_WAIT, clear done.
- IDLE, write_strobe to RD_CMD_PORT with out_port<N_REGS: latch rtc_addr=RTC_ADDR_BASE+out_port, assert rtc_rd_req, go to RD_WAIT, clear done.
- Index >= N_REGS: no bus op and state stays IDLE; set addr_err.
- WR_WAIT/RD_WAIT: hold req, addr and wdata. The counter increments each cycle.
  - Matching done: drop req, set done, go to RECOVER. In RD_WAIT, rdata<=rtc_rdata.
  - Counter reaches TIMEOUT_CYC-1 without done: drop req, set timeout_err, leave rdata unchanged, go to RECOVER.
  - The non-matching done is ignored.
- RECOVER: exactly 1 cycle with req low, then IDLE. This guarantees a one-cycle request gap between back-to-back transactions.
- A command write (window or RD_CMD_PORT) arriving while not in IDLE is dropped and sets overrun. This includes the RECOVER cycle.
- Writes to other ports are ignored. read_strobe never starts a bus transaction.
- If write_strobe and read_strobe coincide, both are honoured independently: the command is processed and the in_port/read-clear path is unaffected.
- Counter width is clog2(TIMEOUT_CYC+1). The counter clears on entering WR_WAIT/RD_WAIT.
- busy is high in WR_WAIT, RD_WAIT and RECOVER.

Test Plan:
- Posted write: write 0x59 to port 0x23 → next cycle rtc_wr_req=1, rtc_addr=4, rtc_wdata=0x59. Done after 5 cycles → req low, busy low 2 cycles later, STATUS reads 0x02.
- Read: write 0x02 to 0x0A → rtc_rd_req=1, rtc_addr=3. rtc_rd_done with rtc_rdata=0x47 → reading port 0x0B gives in_port=0x47 one cycle after port_id set.
- Timeout (TIMEOUT_CYC=8): launch read, never assert done → req drops after 8 cycles, STATUS=0x10, and a second STATUS read gives 0x00.
- Overrun/addr_err: write to 0x25 while WR_WAIT → no second request, STATUS bit2=1. Write 0x10 to 0x0A (N_REGS=16) → no req, bit3=1.
- Reset mid-op: assert reset during RD_WAIT → next cycle rtc_rd_req=0, busy=0, STATUS=0x00, rdata=0x00.
- Back-to-back: second write issued in the cycle after busy falls is accepted, and the request gap is at least 1 cycle.
